fpu_int2float: RTL and testbench
================================

FPU_INT2FLOAT -- requirements
Module: fpu_int2float

Interface
REQ-001 Parameter Std, default 31, IEEE754 word width minus 1.
REQ-002 Parameter Exp, default 7, exponent width minus 1.
REQ-003 Parameter Man, default 22, stored-mantissa width minus 1.
REQ-004 clk  input  1  sole clock, all state updates on rising edge.
REQ-005 rst_l  input  1  reset, synchronous, active-low.
REQ-006 start  input  1  request strobe, accepted only when busy=0.
REQ-007 is_signed  input  1  1=operand two's-complement (fcvt.s.w), 0=unsigned (fcvt.s.wu).
REQ-008 frm  input  3  rounding mode: 000 RNE, 001 RTZ, 010 RDN, 011 RUP, 100 RMM.
REQ-009 int_in  input  32  integer operand.
REQ-010 busy  output  1  high while a conversion is in flight.
REQ-011 valid  output  1  one-cycle pulse, result and flag_nx valid.
REQ-012 result  output  Std+1  IEEE754 single-precision result.
REQ-013 flag_nx  output  1  inexact flag for the completed conversion.

Function
REQ-014 FSM states shall be IDLE, NORM, ROUND, DONE; busy=1 in every state except IDLE.
REQ-015 In IDLE with start=1, the block shall register sign=is_signed&int_in[31], magnitude=sign?(-int_in):int_in as 32-bit unsigned, exponent=158, frm, and go to NORM; if magnitude=0 it shall instead go to DONE with result=0, flag_nx=0.
REQ-016 frm values 101, 110, 111 shall be treated as RNE.
REQ-017 In NORM, if magnitude[31]=1 the block shall go to ROUND; otherwise it shall shift magnitude left by 1, decrement exponent by 1, and stay in NORM.
REQ-018 In ROUND, mantissa=magnitude[30:8], guard=magnitude[7], sticky=OR(magnitude[6:0]).
REQ-019 Round-up: RNE guard&(sticky|mantissa[0]); RTZ 0; RDN sign&(guard|sticky); RUP ~sign&(guard|sticky); RMM guard.
REQ-020 Mantissa carry-out on round-up shall increment exponent and zero the mantissa; exponent overflow is impossible and needs no handling.
REQ-021 ROUND shall register result={sign,exponent[7:0],rounded mantissa} and flag_nx=guard|sticky, then go to DONE.
REQ-022 DONE shall drive valid=1 for exactly that cycle and return to IDLE.
REQ-023 Latency: start accepted at edge k; nonzero operand gives valid in cycle k+lz+3, where lz=leading zeros of magnitude (3..34 cycles); zero operand gives valid in cycle k+1.
REQ-024 start while busy=1 shall be ignored, with no effect on the in-flight conversion.
REQ-025 result and flag_nx shall hold their last values until the next ROUND or zero-operand capture.
REQ-026 start in the DONE cycle shall be ignored, because busy=1 in DONE.

Reset
REQ-027 rst_l=0 at a rising edge shall force state=IDLE, busy=0, valid=0, result=0, flag_nx=0, regardless of start.
REQ-028 Reset mid-conversion shall abort it; no valid pulse shall follow for the aborted operation.

Verification
REQ-029 is_signed=1, int_in=1, RNE -> result 0x3F800000, flag_nx=0, valid 34 cycles after start; is_signed=1, int_in=0xFFFFFFFF -> 0xBF800000.
REQ-030 is_signed=1, int_in=0x80000000 -> 0xCF000000, flag_nx=0, valid 3 cycles after start; is_signed=0, int_in=0 -> 0x00000000, valid 1 cycle after start.
REQ-031 is_signed=0, int_in=0xFFFFFFFF: RNE -> 0x4F800000, flag_nx=1; RTZ -> 0x4F7FFFFF, flag_nx=1.
REQ-032 is_signed=0, int_in=0x01000001: RNE -> 0x4B800000, flag_nx=1 (tie to even); RUP -> 0x4B800001; RMM -> 0x4B800001.
REQ-033 Second start pulse with different int_in while busy=1 -> first operand's result unchanged, exactly one valid pulse.
REQ-034 rst_l=0 for one cycle during NORM of int_in=1 -> busy=0 and result=0 next cycle, no valid; a fresh start afterwards converts normally.

Source files
------------

// File: rtl/fpu_int2float.sv
// Multi-cycle 32-bit integer to IEEE754 single conversion (fcvt.s.w / fcvt.s.wu).
// Normalises one bit per cycle; valid pulses k+lz+3 after start (k+1 for zero); start ignored while busy.
module fpu_int2float #(
  parameter int Std = 31,
  parameter int Exp = 7,
  parameter int Man = 22
) (
  input  logic           clk,
  input  logic           rst_l,
  input  logic           start,
  input  logic           is_signed,
  input  logic [2:0]     frm,
  input  logic [31:0]    int_in,
  output logic           busy,
  output logic           valid,
  output logic [Std:0]   result,
  output logic           flag_nx
);

  localparam int GBit = 30 - Man - 1;

  typedef enum logic [1:0] {IDLE, NORM, ROUND, DONE} state_t;

  state_t         state_q, state_d;
  logic [31:0]    mag_q, mag_d;
  logic [Exp:0]   exp_q, exp_d;
  logic           sign_q, sign_d;
  logic [2:0]     frm_q, frm_d;
  logic [Std:0]   result_q, result_d;
  logic           nx_q, nx_d;

  logic           sign_in;
  logic [31:0]    mag_in;
  logic [Man:0]   mant;
  logic [Man:0]   mant_rnd;
  logic           carry;
  logic           guard;
  logic           sticky;
  logic           round_up;

  always_comb begin
    sign_in = is_signed & int_in[31];
    mag_in  = sign_in ? (-int_in) : int_in;

    mant   = mag_q[30 -: Man+1];
    guard  = mag_q[GBit];
    sticky = |mag_q[GBit-1:0];

    case (frm_q)
      3'd1:    round_up = 1'b0;
      3'd2:    round_up = sign_q & (guard | sticky);
      3'd3:    round_up = ~sign_q & (guard | sticky);
      3'd4:    round_up = guard;
      default: round_up = guard & (sticky | mant[0]);
    endcase

    // A carry out leaves mant_rnd at zero, which is exactly the renormalised mantissa.
    {carry, mant_rnd} = {1'b0, mant} + (Man+2)'(round_up);
  end

  always_comb begin
    state_d  = state_q;
    mag_d    = mag_q;
    exp_d    = exp_q;
    sign_d   = sign_q;
    frm_d    = frm_q;
    result_d = result_q;
    nx_d     = nx_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          sign_d = sign_in;
          mag_d  = mag_in;
          exp_d  = (Exp+1)'(158);
          frm_d  = (frm > 3'd4) ? 3'd0 : frm;
          if (mag_in == 32'd0) begin
            state_d  = DONE;
            result_d = '0;
            nx_d     = 1'b0;
          end else begin
            state_d = NORM;
          end
        end
      end
      NORM: begin
        if (mag_q[31]) begin
          state_d = ROUND;
        end else begin
          mag_d = mag_q << 1;
          exp_d = exp_q - (Exp+1)'(1);
        end
      end
      ROUND: begin
        result_d = {sign_q, exp_q + (Exp+1)'(carry), mant_rnd};
        nx_d     = guard | sticky;
        state_d  = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_l) begin
      state_q  <= IDLE;
      mag_q    <= '0;
      exp_q    <= '0;
      sign_q   <= 1'b0;
      frm_q    <= 3'd0;
      result_q <= '0;
      nx_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      mag_q    <= mag_d;
      exp_q    <= exp_d;
      sign_q   <= sign_d;
      frm_q    <= frm_d;
      result_q <= result_d;
      nx_q     <= nx_d;
    end
  end

  assign busy    = (state_q != IDLE);
  assign valid   = (state_q == DONE);
  assign result  = result_q;
  assign flag_nx = nx_q;

endmodule

// File: tb/tb_fpu_int2float.sv
// Directed bench for fpu_int2float: results, flags, latency, busy blocking and reset abort.
module tb_fpu_int2float;

  logic        clk = 1'b0;
  logic        rst_l;
  logic        start;
  logic        is_signed;
  logic [2:0]  frm;
  logic [31:0] int_in;
  logic        busy;
  logic        valid;
  logic [31:0] result;
  logic        flag_nx;

  int checks = 0;
  int errors = 0;

  fpu_int2float dut (
    .clk       (clk),
    .rst_l     (rst_l),
    .start     (start),
    .is_signed (is_signed),
    .frm       (frm),
    .int_in    (int_in),
    .busy      (busy),
    .valid     (valid),
    .result    (result),
    .flag_nx   (flag_nx)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  // Latency counts edges from the start edge to the edge at which valid is high.
  task automatic conv(input string tag, input logic sg, input logic [2:0] fm,
                      input logic [31:0] val, input logic [31:0] er,
                      input logic enx, input int elat);
    int n;
    @(negedge clk);
    start = 1'b1; is_signed = sg; frm = fm; int_in = val;
    @(posedge clk);
    n = 0;
    do begin
      @(negedge clk);
      start = 1'b0;
      n++;
    end while (!valid && n < 60);
    check($sformatf("%s valid", tag), 32'(valid), 32'd1);
    check($sformatf("%s latency", tag), 32'(n), 32'(elat));
    check($sformatf("%s result", tag), result, er);
    check($sformatf("%s flag_nx", tag), 32'(flag_nx), 32'(enx));
    @(negedge clk);
    check($sformatf("%s pulse width", tag), 32'(valid), 32'd0);
  endtask

  initial begin
    int pulses;
    int n;
    logic [31:0] cap;

    rst_l = 1'b0; start = 1'b1; is_signed = 1'b0; frm = 3'd0; int_in = 32'd7;
    repeat (2) @(posedge clk);
    #1;
    check("reset busy", 32'(busy), 32'd0);
    check("reset valid", 32'(valid), 32'd0);
    check("reset result", result, 32'd0);
    check("reset flag_nx", 32'(flag_nx), 32'd0);
    @(negedge clk);
    start = 1'b0; rst_l = 1'b1;

    conv("s1 rne",        1'b1, 3'd0, 32'h0000_0001, 32'h3F80_0000, 1'b0, 34);
    conv("s-1 rne",       1'b1, 3'd0, 32'hFFFF_FFFF, 32'hBF80_0000, 1'b0, 34);
    conv("smin rne",      1'b1, 3'd0, 32'h8000_0000, 32'hCF00_0000, 1'b0, 3);
    conv("u0",            1'b0, 3'd0, 32'h0000_0000, 32'h0000_0000, 1'b0, 1);
    conv("umax rne",      1'b0, 3'd0, 32'hFFFF_FFFF, 32'h4F80_0000, 1'b1, 3);
    conv("umax rtz",      1'b0, 3'd1, 32'hFFFF_FFFF, 32'h4F7F_FFFF, 1'b1, 3);
    conv("tie rne",       1'b0, 3'd0, 32'h0100_0001, 32'h4B80_0000, 1'b1, 10);
    conv("tie rup",       1'b0, 3'd3, 32'h0100_0001, 32'h4B80_0001, 1'b1, 10);
    conv("tie rmm",       1'b0, 3'd4, 32'h0100_0001, 32'h4B80_0001, 1'b1, 10);
    conv("tie rdn pos",   1'b0, 3'd2, 32'h0100_0001, 32'h4B80_0000, 1'b1, 10);
    conv("s-3 exact",     1'b1, 3'd2, 32'hFFFF_FFFD, 32'hC040_0000, 1'b0, 33);
    conv("neg rdn",       1'b1, 3'd2, 32'h8000_0001, 32'hCF00_0000, 1'b1, 4);
    conv("neg rtz",       1'b1, 3'd1, 32'h8000_0001, 32'hCEFF_FFFF, 1'b1, 4);
    conv("neg rup",       1'b1, 3'd3, 32'h8000_0001, 32'hCEFF_FFFF, 1'b1, 4);
    conv("odd tie frm7",  1'b0, 3'd7, 32'h0100_0003, 32'h4B80_0002, 1'b1, 10);
    conv("odd tie rtz",   1'b0, 3'd1, 32'h0100_0003, 32'h4B80_0001, 1'b1, 10);
    conv("u 0x80000000",  1'b0, 3'd0, 32'h8000_0000, 32'h4F00_0000, 1'b0, 3);

    // Second start while busy must not disturb the in-flight conversion.
    @(negedge clk);
    start = 1'b1; is_signed = 1'b1; frm = 3'd0; int_in = 32'h0000_0001;
    @(negedge clk);
    start = 1'b1; int_in = 32'h8000_0000;
    @(negedge clk);
    start = 1'b0;
    pulses = 0; cap = 32'hDEAD_BEEF;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (valid) begin
        pulses++;
        cap = result;
      end
    end
    check("busy-ignore pulses", 32'(pulses), 32'd1);
    check("busy-ignore result", cap, 32'h3F80_0000);

    // Start presented during the DONE cycle is dropped.
    @(negedge clk);
    start = 1'b1; is_signed = 1'b1; frm = 3'd0; int_in = 32'h8000_0000;
    @(posedge clk);
    n = 0;
    do begin
      @(negedge clk);
      start = 1'b0;
      n++;
    end while (!valid && n < 60);
    check("done-start valid", 32'(valid), 32'd1);
    start = 1'b1; is_signed = 1'b0; int_in = 32'h0000_0005;
    @(posedge clk);
    #1;
    check("done-start busy", 32'(busy), 32'd0);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("result hold", result, 32'hCF00_0000);
    check("idle busy", 32'(busy), 32'd0);

    // Reset during NORM aborts without a valid pulse.
    @(negedge clk);
    start = 1'b1; is_signed = 1'b1; frm = 3'd0; int_in = 32'h0000_0001;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    check("pre-reset busy", 32'(busy), 32'd1);
    rst_l = 1'b0;
    @(posedge clk);
    #1;
    check("abort busy", 32'(busy), 32'd0);
    check("abort result", result, 32'd0);
    check("abort valid", 32'(valid), 32'd0);
    @(negedge clk);
    rst_l = 1'b1;
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (valid) pulses++;
    end
    check("abort no pulse", 32'(pulses), 32'd0);
    conv("post-reset s1", 1'b1, 3'd0, 32'h0000_0001, 32'h3F80_0000, 1'b0, 34);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
